unified_mem_arbiter: RTL and testbench

- Shares one single-ported, variable-latency unified memory between the datapath's instruction-fetch port (IM_addr / IM_readData) and its data port (DM_addr / DM_writeData / DM_readData).
- Sequences each access through a req/ack handshake and raises stall so the core's PC and register writes freeze until both of its accesses complete.
- Sits between the datapath and the memory model, replacing the separate instruction and data memories.

---
 rtl/unified_mem_arb_pkg.sv | 21 ++
 rtl/unified_mem_arbiter_wait_counter.sv | 41 ++++
 rtl/unified_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arb_pkg.sv
// unified_mem_arb_pkg
// Shared types and constants for the unified memory arbiter.
//   arb_state_t      : arbiter FSM states (IDLE, BUSY, RESP)
//   arb_grant_t      : which port owns the current transfer (GNT_IF, GNT_DATA)
//   MAX_WAIT_DEFAULT : default BUSY timeout, used only when ARB_TIMEOUT_EN is defined
package unified_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  typedef enum logic {
    GNT_IF,
    GNT_DATA
  } arb_grant_t;

  localparam int MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/unified_mem_arbiter_wait_counter.sv
// arb_wait_counter
// Counts BUSY cycles spent waiting for mem_ready. It is compiled only when
// ARB_TIMEOUT_EN is defined; without that macro no counter exists.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous, active-low reset
//   clear   : restart the count (held while the arbiter is idle)
//   enable  : count this cycle (BUSY and no mem_ready)
//   expired : high during the MAX_WAIT-th enabled cycle, so the abort
//             happens on the edge that ends that cycle
`ifdef ARB_TIMEOUT_EN
module arb_wait_counter
  import unified_mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // count_reg holds the number of completed wait cycles, so the current
  // cycle is wait cycle count_reg+1.
  assign expired = enable && (count_reg == CW'(MAX_WAIT - 1));

endmodule
`endif

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-ported, variable-latency memory between the instruction
// fetch port and the data port. Data has fixed priority; each access runs
// IDLE -> BUSY (mem_req high until mem_ready) -> RESP (one-cycle ack).
// Optional macro ARB_TIMEOUT_EN: abort a BUSY phase after MAX_WAIT cycles
// without mem_ready, acking the port with err=1 and zero read data.
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   if_req/if_addr             : fetch request and address
//   if_rdata/if_ack            : fetched instruction (registered), ack pulse
//   d_req/d_we/d_addr/d_wdata  : data request, store flag, address, store data
//   d_rdata/d_ack              : load data (registered), ack pulse
//   mem_req/mem_we/mem_addr/mem_wdata : memory request bus (registered)
//   mem_rdata/mem_ready        : memory read data and completion
//   stall                      : core must hold its state this cycle
//   err                        : timeout pulse, coincident with the ack
module unified_mem_arbiter
  import unified_mem_arb_pkg::*;
#(
  parameter int N        = 64,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic [31:0]  if_rdata,
  output logic         if_ack,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic [N-1:0] d_rdata,
  output logic         d_ack,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic         stall,
  output logic         err
);

  arb_state_t state_reg, state_next;
  arb_grant_t grant_reg, grant_next;
  logic       timeout;

`ifdef ARB_TIMEOUT_EN
  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_reg == IDLE),
    .enable  ((state_reg == BUSY) && !mem_ready),
    .expired (timeout)
  );
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT != 0);
  assign timeout         = 1'b0;
  assign err             = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    case (state_reg)
      IDLE: begin
        if (d_req) begin
          grant_next = GNT_DATA;
          state_next = BUSY;
        end else if (if_req) begin
          grant_next = GNT_IF;
          state_next = BUSY;
        end
      end
      // mem_ready wins over a same-cycle timeout because it is tested first
      // in the datapath below; both leave BUSY the same way.
      BUSY:    if (mem_ready || timeout) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      grant_reg <= GNT_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (d_req) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (if_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
          end
        end
        BUSY: begin
          if (mem_ready || timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            // mem_we still carries the granted d_we, so it tells load from store.
            if (grant_reg == GNT_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata[31:0] : '0;
            end else begin
              d_ack <= 1'b1;
              if (!mem_we) d_rdata <= mem_ready ? mem_rdata : '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= (state_reg == BUSY) && timeout && !mem_ready;
    end
  end
`endif

  // Core freezes while either of its requests is outstanding.
  assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter
// Directed bench for unified_mem_arbiter. Inputs change and outputs are
// checked 1 ns after each rising edge; the bench plays the memory by driving
// mem_ready/mem_rdata cycle by cycle. Timeout cases are compiled only when
// ARB_TIMEOUT_EN is defined (MAX_WAIT is set to 4 here).
module tb_unified_mem_arbiter;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         if_req;
  logic [N-1:0] if_addr;
  logic [31:0]  if_rdata;
  logic         if_ack;
  logic         d_req;
  logic         d_we;
  logic [N-1:0] d_addr;
  logic [N-1:0] d_wdata;
  logic [N-1:0] d_rdata;
  logic         d_ack;
  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         mem_ready;
  logic         stall;
  logic         err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .N        (N),
    .MAX_WAIT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall     (stall),
    .err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Idle bus: no request, no acks, no error.
  task automatic check_idle(input string tag);
    check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, "_if_ack"},  64'(if_ack),  64'd0);
    check({tag, "_d_ack"},   64'(d_ack),   64'd0);
  endtask

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    check_idle("rst");
    check("rst_mem_we",   64'(mem_we),   64'd0);
    check("rst_mem_addr", mem_addr,      64'd0);
    check("rst_if_rdata", 64'(if_rdata), 64'd0);
    check("rst_d_rdata",  d_rdata,       64'd0);
    check("rst_err",      64'(err),      64'd0);
    $display("txn reset: done");
    reset = 1'b1;
    tick();

    // ---------------- fetch 0x40, immediate ready ----------------
    if_req = 1'b1; if_addr = 64'h40;                 // cycle 0
    #1 check("f1_stall_c0", 64'(stall), 64'd1);
    tick();                                           // cycle 1
    check("f1_mem_req",  64'(mem_req), 64'd1);
    check("f1_mem_addr", mem_addr,     64'h40);
    check("f1_mem_we",   64'(mem_we),  64'd0);
    check("f1_stall_c1", 64'(stall),   64'd1);
    mem_ready = 1'b1; mem_rdata = 64'h00A00093;
    tick();                                           // cycle 2
    mem_ready = 1'b0;
    check("f1_if_ack",   64'(if_ack),   64'd1);
    check("f1_if_rdata", 64'(if_rdata), 64'h00A00093);
    check("f1_stall_c2", 64'(stall),    64'd0);
    check("f1_mem_req",  64'(mem_req),  64'd0);
    check("f1_err",      64'(err),      64'd0);
    $display("txn fetch addr=0x40 rdata=%h", if_rdata);
    if_req = 1'b0;
    tick();                                           // cycle 3
    check_idle("f1_after");

    // ---------------- load 0x100, three wait cycles ----------------
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;      // cycle 0
    for (int c = 1; c <= 4; c++) begin
      tick();                                         // cycles 1..4
      check($sformatf("ld_mem_req_c%0d", c),  64'(mem_req), 64'd1);
      check($sformatf("ld_mem_addr_c%0d", c), mem_addr,     64'h100);
      check($sformatf("ld_d_ack_c%0d", c),    64'(d_ack),   64'd0);
      if (c == 4) begin
        mem_ready = 1'b1; mem_rdata = 64'hDEADBEEF;
      end
    end
    tick();                                           // cycle 5
    mem_ready = 1'b0;
    check("ld_d_ack",   64'(d_ack),  64'd1);
    check("ld_d_rdata", d_rdata,     64'hDEADBEEF);
    check("ld_if_ack",  64'(if_ack), 64'd0);
    $display("txn load addr=0x100 rdata=%h", d_rdata);
    d_req = 1'b0;
    tick();
    check_idle("ld_after");

    // ---------------- simultaneous store 0x200 and fetch 0x44 ----------------
    if_req = 1'b1; if_addr = 64'h44;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h200; d_wdata = 64'h55;
    tick();                                           // cycle 1: store in BUSY
    check("sim_st_mem_we",    64'(mem_we), 64'd1);
    check("sim_st_mem_addr",  mem_addr,    64'h200);
    check("sim_st_mem_wdata", mem_wdata,   64'h55);
    mem_ready = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();                                           // cycle 2: d_ack
    mem_ready = 1'b0;
    check("sim_d_ack",       64'(d_ack),  64'd1);
    check("sim_if_ack_c2",   64'(if_ack), 64'd0);
    check("sim_d_rdata_kept", d_rdata,    64'hDEADBEEF);
    check("sim_stall_c2",    64'(stall),  64'd1);
    $display("txn store addr=0x200 wdata=0x55 ack=%0b", d_ack);
    d_req = 1'b0; d_we = 1'b0;
    tick();                                           // cycle 3: IDLE
    check("sim_idle_mem_req", 64'(mem_req), 64'd0);
    tick();                                           // cycle 4: fetch BUSY
    check("sim_f_mem_req",  64'(mem_req), 64'd1);
    check("sim_f_mem_addr", mem_addr,     64'h44);
    check("sim_f_mem_we",   64'(mem_we),  64'd0);
    mem_ready = 1'b1; mem_rdata = 64'hCAFE0000_00400013;
    tick();                                           // cycle 5: if_ack
    mem_ready = 1'b0;
    check("sim_if_ack",   64'(if_ack),   64'd1);
    check("sim_if_rdata", 64'(if_rdata), 64'h00400013);
    $display("txn fetch addr=0x44 rdata=%h", if_rdata);
    if_req = 1'b0;
    tick();

    // ---------------- reset during BUSY, held request restarts ----------------
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300;
    tick();                                           // cycle 1: BUSY
    check("rb_mem_req_busy", 64'(mem_req), 64'd1);
    reset = 1'b0;
    tick();                                           // cycle 2: after reset edge
    check_idle("rb_reset");
    check("rb_mem_addr", mem_addr, 64'd0);
    check("rb_d_rdata",  d_rdata,  64'd0);
    reset = 1'b1;
    tick();                                           // cycle 3: fresh BUSY
    check("rb_restart_req",  64'(mem_req), 64'd1);
    check("rb_restart_addr", mem_addr,     64'h300);
    mem_ready = 1'b1; mem_rdata = 64'h77;
    tick();                                           // cycle 4
    mem_ready = 1'b0;
    check("rb_d_ack",   64'(d_ack), 64'd1);
    check("rb_d_rdata_new", d_rdata, 64'h77);
    $display("txn reset-in-busy restart addr=0x300 rdata=%h", d_rdata);
    d_req = 1'b0;
    tick();

    // ---------------- back-to-back fetches ----------------
    if_req = 1'b1; if_addr = 64'h80;                 // cycle 0
    tick();                                           // cycle 1
    check("bb1_mem_addr", mem_addr, 64'h80);
    mem_ready = 1'b1; mem_rdata = 64'h11;
    tick();                                           // cycle 2: RESP, req held
    mem_ready = 1'b0;
    check("bb1_if_ack",   64'(if_ack),   64'd1);
    check("bb1_if_rdata", 64'(if_rdata), 64'h11);
    tick();                                           // cycle 3: no duplicate grant
    check_idle("bb_gap");
    if_req = 1'b0;
    tick();                                           // cycle 4
    check("bb_gap2_mem_req", 64'(mem_req), 64'd0);
    if_req = 1'b1; if_addr = 64'h84;
    tick();                                           // cycle 5
    check("bb2_mem_req",  64'(mem_req), 64'd1);
    check("bb2_mem_addr", mem_addr,     64'h84);
    mem_ready = 1'b1; mem_rdata = 64'h22;
    tick();                                           // cycle 6
    mem_ready = 1'b0;
    check("bb2_if_ack",   64'(if_ack),   64'd1);
    check("bb2_if_rdata", 64'(if_rdata), 64'h22);
    $display("txn back-to-back fetch 0x80/0x84 rdata=%h", if_rdata);
    if_req = 1'b0;
    tick();
    check_idle("bb_after");

`ifdef ARB_TIMEOUT_EN
    // ---------------- timeout: load never answered ----------------
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h400;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("to_mem_req_c%0d", c), 64'(mem_req), 64'd1);
      check($sformatf("to_d_ack_c%0d", c),   64'(d_ack),   64'd0);
    end
    tick();                                           // cycle 5
    check("to_d_ack",   64'(d_ack),   64'd1);
    check("to_err",     64'(err),     64'd1);
    check("to_mem_req", 64'(mem_req), 64'd0);
    check("to_d_rdata", d_rdata,      64'd0);
    $display("txn timeout load addr=0x400 err=%0b", err);
    d_req = 1'b0;
    tick();
    check("to_err_clear", 64'(err), 64'd0);

    // ---------------- timeout cycle with mem_ready: normal completion ----------------
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h408;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("tr_mem_req_c%0d", c), 64'(mem_req), 64'd1);
      if (c == 4) begin
        mem_ready = 1'b1; mem_rdata = 64'h99;
      end
    end
    tick();
    mem_ready = 1'b0;
    check("tr_d_ack",   64'(d_ack), 64'd1);
    check("tr_err",     64'(err),   64'd0);
    check("tr_d_rdata", d_rdata,    64'h99);
    $display("txn ready-at-timeout load addr=0x408 rdata=%h", d_rdata);
    d_req = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
